// File: rtl/bitcount_seq.sv
// Sequential bit counter: captures a word on start, scans it L bits per cycle
// from the MSB, and reports ones, zeros or leading zeros with a done pulse.
module bitcount_seq #(
    parameter int W = 8,
    parameter int L = 1,
    localparam int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    sel,
    input  logic [W-1:0]  a_in,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cntout
);

    localparam int N  = W / L;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LC = CW'(L);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  word_q,  word_d;
    logic [1:0]    mode_q,  mode_d;
    logic [CW-1:0] acc_q,   acc_d;
    logic [KW-1:0] k_q,     k_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    logic [L-1:0]  chunk;
    logic [CW-1:0] pop;
    logic [CW-1:0] lz;
    logic [CW-1:0] contrib;
    logic          run;
    logic          last;

    // The word is shifted left after each chunk, so the current chunk is always the top L bits.
    always_comb begin
        chunk = word_q[W-1 -: L];
        pop   = '0;
        lz    = '0;
        run   = 1'b1;
        for (int unsigned j = 0; j < L; j++) begin
            pop = pop + CW'(chunk[j]);
            run = run & ~chunk[L-1-j];
            lz  = lz + CW'(run);
        end
        case (mode_q)
            2'b01:   contrib = LC - pop;
            2'b10:   contrib = pop;
            2'b11:   contrib = lz;
            default: contrib = '0;
        endcase
        last = (k_q == KW'(N - 1)) || ((mode_q == 2'b11) && (|chunk));
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    word_d = a_in;
                    mode_d = sel;
                    acc_d  = '0;
                    k_d    = '0;
                    if (sel == 2'b00) begin
                        state_d = DONE;
                        cnt_d   = '0;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                acc_d  = acc_q + contrib;
                k_d    = k_q + KW'(1);
                word_d = word_q << L;
                if (last) begin
                    cnt_d   = acc_q + contrib;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            mode_q  <= '0;
            acc_q   <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy   = (state_q == SCAN);
    assign done   = (state_q == DONE);
    assign cntout = cnt_q;

endmodule

// File: tb/tb_bitcount_seq.sv
// Bench for bitcount_seq: one instance with L=1 and one with L=2, checked
// cycle by cycle against a word-level reference model.
module tb_bitcount_seq;

    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start_s [2];
    logic [1:0]    sel_s   [2];
    logic [W-1:0]  a_s     [2];
    logic          busy_s  [2];
    logic          done_s  [2];
    logic [CW-1:0] cnt_s   [2];
    logic [CW-1:0] exp_cnt [2];

    int vectors     = 0;
    int miscompares = 0;

    bitcount_seq #(.W(W), .L(1)) u_l1 (
        .clk(clk), .rst(rst), .start(start_s[0]), .sel(sel_s[0]), .a_in(a_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .cntout(cnt_s[0])
    );

    bitcount_seq #(.W(W), .L(2)) u_l2 (
        .clk(clk), .rst(rst), .start(start_s[1]), .sel(sel_s[1]), .a_in(a_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .cntout(cnt_s[1])
    );

    function automatic int lanes(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic int count_ones(input logic [W-1:0] w);
        int c = 0;
        for (int i = 0; i < W; i++) if (w[i]) c++;
        return c;
    endfunction

    function automatic int lead_zeros(input logic [W-1:0] w);
        int z = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (w[i]) break;
            z++;
        end
        return z;
    endfunction

    function automatic int ref_result(input logic [W-1:0] w, input logic [1:0] m);
        case (m)
            2'b01:   return W - count_ones(w);
            2'b10:   return count_ones(w);
            2'b11:   return lead_zeros(w);
            default: return 0;
        endcase
    endfunction

    // Edges after the accept edge until done is visible.
    function automatic int ref_latency(input int d, input logic [W-1:0] w, input logic [1:0] m);
        if (m == 2'b00) return 0;
        if (m == 2'b11 && w != 0) return lead_zeros(w) / lanes(d) + 1;
        return W / lanes(d);
    endfunction

    task automatic run_txn(input int d, input logic [W-1:0] w, input logic [1:0] m,
                           input logic [W-1:0] post, input bit noisy, input string name);
        int lat = ref_latency(d, w, m);
        logic [CW-1:0] res = CW'(ref_result(w, m));
        logic edone, ebusy;
        logic [CW-1:0] ecnt;
        @(negedge clk);
        a_s[d] = w; sel_s[d] = m; start_s[d] = 1'b1;
        for (int j = 0; j <= lat + 1; j++) begin
            @(negedge clk);
            if (j == 0) begin
                a_s[d]   = post;
                sel_s[d] = noisy ? 2'($urandom) : ~m;
            end
            edone = (j == lat);
            ebusy = (j < lat);
            ecnt  = (j < lat) ? exp_cnt[d] : res;
            vectors++;
            if (done_s[d] !== edone) begin
                miscompares++;
                $display("FAIL %s u%0d step%0d done: got %b want %b", name, d, j, done_s[d], edone);
            end
            vectors++;
            if (busy_s[d] !== ebusy) begin
                miscompares++;
                $display("FAIL %s u%0d step%0d busy: got %b want %b", name, d, j, busy_s[d], ebusy);
            end
            vectors++;
            if (cnt_s[d] !== ecnt) begin
                miscompares++;
                $display("FAIL %s u%0d step%0d cntout: got %0d want %0d", name, d, j, cnt_s[d], ecnt);
            end
            start_s[d] = (noisy && j < lat) ? 1'($urandom) : 1'b0;
            if (noisy && j < lat) a_s[d] = W'($urandom);
        end
        exp_cnt[d] = res;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; sel_s[d] = 2'b00; a_s[d] = '0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (busy_s[d] !== 1'b0 || done_s[d] !== 1'b0 || cnt_s[d] !== '0) begin
                miscompares++;
                $display("FAIL reset u%0d busy/done/cnt: got %b/%b/%0d want 0/0/0",
                         d, busy_s[d], done_s[d], cnt_s[d]);
            end
            exp_cnt[d] = '0;
        end
        rst = 1'b0;
    endtask

    task automatic test_ones();
        run_txn(0, 8'b0000_1011, 2'b10, 8'hFF, 1'b0, "ones_l1");
    endtask

    task automatic test_x_isolation();
        run_txn(0, 8'b0100_0010, 2'b10, {W{1'bx}}, 1'b0, "xiso_ones");
        run_txn(0, 8'b0100_0010, 2'b01, {W{1'bx}}, 1'b0, "xiso_zeros");
    endtask

    task automatic test_leading_zeros();
        run_txn(1, 8'b0001_0110, 2'b11, {W{1'bx}}, 1'b0, "lz_16");
        run_txn(1, 8'h00,        2'b11, 8'hFF,     1'b0, "lz_00");
        run_txn(1, 8'h80,        2'b11, 8'h00,     1'b0, "lz_80");
        run_txn(0, 8'h01,        2'b11, 8'h00,     1'b0, "lz_01_l1");
    endtask

    task automatic test_sel_none();
        run_txn(0, 8'hA5, 2'b00, 8'hFF, 1'b0, "none_l1");
        run_txn(1, 8'hFF, 2'b00, 8'h00, 1'b0, "none_l2");
    endtask

    // Start held through the scan and into the DONE cycle.
    task automatic test_back_to_back();
        logic edone, ebusy;
        logic [CW-1:0] ecnt;
        @(negedge clk);
        a_s[1] = 8'hFF; sel_s[1] = 2'b10; start_s[1] = 1'b1;
        for (int j = 0; j <= 10; j++) begin
            @(negedge clk);
            if (j == 0) a_s[1] = 8'h0F;
            edone = (j == 4) || (j == 9);
            ebusy = (j < 4) || (j >= 5 && j < 9);
            ecnt  = (j < 4) ? exp_cnt[1] : (j < 9) ? CW'(8) : CW'(4);
            vectors++;
            if (done_s[1] !== edone || busy_s[1] !== ebusy || cnt_s[1] !== ecnt) begin
                miscompares++;
                $display("FAIL b2b step%0d done/busy/cnt: got %b/%b/%0d want %b/%b/%0d",
                         j, done_s[1], busy_s[1], cnt_s[1], edone, ebusy, ecnt);
            end
            if (j == 5) start_s[1] = 1'b0;
        end
        exp_cnt[1] = CW'(4);
    endtask

    task automatic test_reset_mid_scan();
        @(negedge clk);
        a_s[0] = 8'hFF; sel_s[0] = 2'b10; start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (busy_s[d] !== 1'b0 || done_s[d] !== 1'b0 || cnt_s[d] !== '0) begin
                miscompares++;
                $display("FAIL midrst u%0d busy/done/cnt: got %b/%b/%0d want 0/0/0",
                         d, busy_s[d], done_s[d], cnt_s[d]);
            end
            exp_cnt[d] = '0;
        end
        @(negedge clk);
        vectors++;
        if (done_s[0] !== 1'b0 || busy_s[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_after done/busy: got %b/%b want 0/0", done_s[0], busy_s[0]);
        end
        run_txn(0, 8'hFF, 2'b10, 8'h00, 1'b0, "after_rst");
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        logic [1:0]   m;
        for (int n = 0; n < 60; n++) begin
            int d = n % 2;
            w = W'($urandom);
            if ($urandom_range(0, 3) == 0) w = w >> $urandom_range(0, W);
            m = 2'($urandom);
            run_txn(d, w, m, W'($urandom), 1'b1, "random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_x_isolation();
        test_leading_zeros();
        test_sel_none();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
